dacscan: RTL and testbench

- Parametrised successor to the DAC/comparator register block.
- Owns per-channel DAC thresholds and per-channel signed offsets, and runs its own channel-scan FSM.
- Each enabled channel is serviced either as a threshold compare or as a DW-bit SAR conversion.
- Results are latched into COMPI/STA/SARV registers with interrupt generation; the block sits between the SFR write decode and the analog DAC/comparator mux.

---
 rtl/dacscan.sv | 268 ++++++++++++++++++++++++++
 tb/tb_dacscan.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dacscan.sv
// dacscan - DAC threshold / offset register block with its own channel-scan FSM.
//
// Holds per-channel DAC thresholds and signed offsets. A scan walks channels
// 0..N_CH-1; each enabled channel is serviced either as a single threshold
// compare (DACEN) or as a DW-bit successive-approximation conversion (SAREN).
// Results land in r_comp/r_sta (compare) or r_sarv (SAR).
//
// Ports:
//   clk, srstz               clock, asynchronous active-low reset
//   v_upd/v_wdat             per-channel threshold write strobe and data
//   ofs_upd/ofs_wdat         per-channel signed offset write strobe and data
//   en_wr/sar_wr/en_wdat     DACEN / SAREN writes (may coincide)
//   sta_clr                  write-1-to-clear for r_sta
//   run                      scan enable (level)
//   comp_i                   synchronised comparator, 1 = input >= dac_code
//   cs_ptr, dac_code         analog mux channel and DAC code
//   busy, cycle_done         FSM not idle, one-clock end-of-scan pulse
//   r_*                      register contents, channel i at [DW*i +: DW]
//   o_intr                   OR of r_sta
module dacscan #(
    parameter int N_CH    = 18,
    parameter int DW      = 8,
    parameter int BIT_PTR = 5,
    parameter int SETTLE  = 4
) (
    input  logic                 clk,
    input  logic                 srstz,
    input  logic [N_CH-1:0]      v_upd,
    input  logic [DW-1:0]        v_wdat,
    input  logic [N_CH-1:0]      ofs_upd,
    input  logic [DW-1:0]        ofs_wdat,
    input  logic                 en_wr,
    input  logic                 sar_wr,
    input  logic [N_CH-1:0]      en_wdat,
    input  logic [N_CH-1:0]      sta_clr,
    input  logic                 run,
    input  logic                 comp_i,
    output logic [BIT_PTR-1:0]   cs_ptr,
    output logic [DW-1:0]        dac_code,
    output logic                 busy,
    output logic                 cycle_done,
    output logic [N_CH-1:0]      r_dac_en,
    output logic [N_CH-1:0]      r_sar_en,
    output logic [N_CH-1:0]      r_comp,
    output logic [N_CH-1:0]      r_sta,
    output logic [DW*N_CH-1:0]   r_dacvs,
    output logic [DW*N_CH-1:0]   r_ofs,
    output logic [DW*N_CH-1:0]   r_sarv,
    output logic                 o_intr
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int BW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);
    localparam logic [BW-1:0] BIDX_TOP = BW'(DW - 1);
    localparam logic [DW-1:0] TRIAL_ONE = DW'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEEK = 3'd1,
        S_CMP  = 3'd2,
        S_SAR  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_r;
    logic [CW-1:0]     cnt_r;
    logic [BW-1:0]     bidx_r;
    logic [DW-1:0]     trial_r;

    logic [DW-1:0]     v_sel_s;
    logic [DW-1:0]     ofs_sel_s;
    logic              act_dac_s;
    logic              act_sar_s;
    logic              old_comp_s;
    logic [N_CH-1:0]   ptr_mask_s;
    logic [N_CH-1:0]   sta_set_s;
    logic [DW-1:0]     sar_bit_s;
    state_t            adv_state_s;
    logic [BIT_PTR-1:0] adv_ptr_s;
    logic              cnt_zero_s;

    // Offset-corrected threshold, saturated at 0 / all-ones on over/underflow.
    function automatic logic [DW-1:0] eff_code(input logic [DW-1:0] v, input logic [DW-1:0] ofs);
        logic [DW:0] sum;
        sum = {1'b0, v} + {ofs[DW-1], ofs};
        if (sum[DW]) begin
            if (ofs[DW-1]) begin
                eff_code = {DW{1'b0}};
            end else begin
                eff_code = {DW{1'b1}};
            end
        end else begin
            eff_code = sum[DW-1:0];
        end
    endfunction

    // Per-channel fields of the channel currently pointed to.
    always_comb begin
        v_sel_s    = {DW{1'b0}};
        ofs_sel_s  = {DW{1'b0}};
        act_dac_s  = 1'b0;
        act_sar_s  = 1'b0;
        old_comp_s = 1'b0;
        ptr_mask_s = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            if (BIT_PTR'(i) == cs_ptr) begin
                v_sel_s       = r_dacvs[DW*i +: DW];
                ofs_sel_s     = r_ofs[DW*i +: DW];
                act_dac_s     = r_dac_en[i];
                act_sar_s     = r_sar_en[i];
                old_comp_s    = r_comp[i];
                ptr_mask_s[i] = 1'b1;
            end else begin
                ptr_mask_s[i] = 1'b0;
            end
        end
    end

    assign cnt_zero_s = (cnt_r == {CW{1'b0}});

    // Where the scan goes after finishing the current channel.
    always_comb begin
        if (cs_ptr == BIT_PTR'(N_CH - 1)) begin
            adv_state_s = S_DONE;
            adv_ptr_s   = cs_ptr;
        end else if (!run) begin
            adv_state_s = S_IDLE;
            adv_ptr_s   = {BIT_PTR{1'b0}};
        end else begin
            adv_state_s = S_SEEK;
            adv_ptr_s   = cs_ptr + BIT_PTR'(1);
        end
    end

    // Current trial with the bit under test resolved by the comparator.
    always_comb begin
        sar_bit_s         = trial_r;
        sar_bit_s[bidx_r] = comp_i;
    end

    // Status set: a finishing compare whose result differs from the stored bit.
    always_comb begin
        if ((state_r == S_CMP) && cnt_zero_s && (comp_i != old_comp_s)) begin
            sta_set_s = ptr_mask_s;
        end else begin
            sta_set_s = {N_CH{1'b0}};
        end
    end

    // DAC code: live offset-corrected threshold in compare, trial in SAR.
    always_comb begin
        dac_code = {DW{1'b0}};
        case (state_r)
            S_CMP:   dac_code = eff_code(v_sel_s, ofs_sel_s);
            S_SAR:   dac_code = trial_r;
            default: dac_code = {DW{1'b0}};
        endcase
    end

    assign busy       = (state_r != S_IDLE);
    assign cycle_done = (state_r == S_DONE);
    assign o_intr     = |r_sta;

    // Software-visible configuration registers, independent of the scan.
    always_ff @(posedge clk or negedge srstz) begin
        if (!srstz) begin
            r_dacvs  <= {(DW*N_CH){1'b0}};
            r_ofs    <= {(DW*N_CH){1'b0}};
            r_dac_en <= {N_CH{1'b0}};
            r_sar_en <= {N_CH{1'b0}};
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (v_upd[i]) begin
                    r_dacvs[DW*i +: DW] <= v_wdat;
                end
                if (ofs_upd[i]) begin
                    r_ofs[DW*i +: DW] <= ofs_wdat;
                end
            end
            if (en_wr) begin
                r_dac_en <= en_wdat;
            end
            if (sar_wr) begin
                r_sar_en <= en_wdat;
            end
        end
    end

    // Scan FSM together with the result registers it owns.
    always_ff @(posedge clk or negedge srstz) begin
        if (!srstz) begin
            state_r <= S_IDLE;
            cs_ptr  <= {BIT_PTR{1'b0}};
            cnt_r   <= {CW{1'b0}};
            bidx_r  <= {BW{1'b0}};
            trial_r <= {DW{1'b0}};
            r_comp  <= {N_CH{1'b0}};
            r_sta   <= {N_CH{1'b0}};
            r_sarv  <= {(DW*N_CH){1'b0}};
        end else begin
            // Set beats clear when both hit the same bit.
            r_sta <= (r_sta & ~sta_clr) | sta_set_s;
            case (state_r)
                S_IDLE: begin
                    cs_ptr <= {BIT_PTR{1'b0}};
                    if (run) begin
                        state_r <= S_SEEK;
                    end
                end
                S_SEEK: begin
                    if (act_sar_s) begin
                        state_r <= S_SAR;
                        cnt_r   <= CNT_LOAD;
                        bidx_r  <= BIDX_TOP;
                        trial_r <= TRIAL_ONE << BIDX_TOP;
                    end else if (act_dac_s) begin
                        state_r <= S_CMP;
                        cnt_r   <= CNT_LOAD;
                    end else begin
                        state_r <= adv_state_s;
                        cs_ptr  <= adv_ptr_s;
                    end
                end
                S_CMP: begin
                    if (cnt_zero_s) begin
                        r_comp  <= comp_i ? (r_comp | ptr_mask_s) : (r_comp & ~ptr_mask_s);
                        state_r <= adv_state_s;
                        cs_ptr  <= adv_ptr_s;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                S_SAR: begin
                    if (!cnt_zero_s) begin
                        cnt_r <= cnt_r - CW'(1);
                    end else if (bidx_r != {BW{1'b0}}) begin
                        trial_r <= sar_bit_s | (TRIAL_ONE << (bidx_r - BW'(1)));
                        bidx_r  <= bidx_r - BW'(1);
                        cnt_r   <= CNT_LOAD;
                    end else begin
                        for (int i = 0; i < N_CH; i++) begin
                            if (ptr_mask_s[i]) begin
                                r_sarv[DW*i +: DW] <= sar_bit_s;
                            end
                        end
                        trial_r <= sar_bit_s;
                        state_r <= adv_state_s;
                        cs_ptr  <= adv_ptr_s;
                    end
                end
                S_DONE: begin
                    cs_ptr <= {BIT_PTR{1'b0}};
                    if (run) begin
                        state_r <= S_SEEK;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    cs_ptr  <= {BIT_PTR{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dacscan.sv
module tb_dacscan;

    localparam int N_CH = 18;
    localparam int DW   = 8;
    localparam int BP   = 5;

    logic              clk;
    logic              srstz;
    logic [N_CH-1:0]   v_upd;
    logic [DW-1:0]     v_wdat;
    logic [N_CH-1:0]   ofs_upd;
    logic [DW-1:0]     ofs_wdat;
    logic              en_wr;
    logic              sar_wr;
    logic [N_CH-1:0]   en_wdat;
    logic [N_CH-1:0]   sta_clr;
    logic              run;
    logic              comp_i;
    logic [BP-1:0]     cs_ptr;
    logic [DW-1:0]     dac_code;
    logic              busy;
    logic              cycle_done;
    logic [N_CH-1:0]   r_dac_en;
    logic [N_CH-1:0]   r_sar_en;
    logic [N_CH-1:0]   r_comp;
    logic [N_CH-1:0]   r_sta;
    logic [DW*N_CH-1:0] r_dacvs;
    logic [DW*N_CH-1:0] r_ofs;
    logic [DW*N_CH-1:0] r_sarv;
    logic              o_intr;

    // comparator model: fixed level, or analog input compared against dac_code
    logic              sar_model;
    logic              comp_lvl;
    logic [DW-1:0]     sar_target;
    assign comp_i = sar_model ? (sar_target >= dac_code) : comp_lvl;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_tr [8];
    logic seen_done;

    dacscan #(.N_CH(N_CH), .DW(DW), .BIT_PTR(BP), .SETTLE(4)) dut (
        .clk(clk), .srstz(srstz),
        .v_upd(v_upd), .v_wdat(v_wdat), .ofs_upd(ofs_upd), .ofs_wdat(ofs_wdat),
        .en_wr(en_wr), .sar_wr(sar_wr), .en_wdat(en_wdat), .sta_clr(sta_clr),
        .run(run), .comp_i(comp_i),
        .cs_ptr(cs_ptr), .dac_code(dac_code), .busy(busy), .cycle_done(cycle_done),
        .r_dac_en(r_dac_en), .r_sar_en(r_sar_en), .r_comp(r_comp), .r_sta(r_sta),
        .r_dacvs(r_dacvs), .r_ofs(r_ofs), .r_sarv(r_sarv), .o_intr(o_intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        run = 1'b0;
        sar_model = 1'b0;
        comp_lvl = 1'b0;
        srstz = 1'b0;
        tick();
        srstz = 1'b1;
    endtask

    task automatic wr_vo(input logic [N_CH-1:0] vm, input logic [N_CH-1:0] om,
                         input logic [DW-1:0] vd, input logic [DW-1:0] od);
        v_upd = vm; ofs_upd = om; v_wdat = vd; ofs_wdat = od;
        tick();
        v_upd = '0; ofs_upd = '0;
    endtask

    task automatic wr_en(input logic de, input logic se, input logic [N_CH-1:0] d);
        en_wr = de; sar_wr = se; en_wdat = d;
        tick();
        en_wr = 1'b0; sar_wr = 1'b0;
    endtask

    initial begin
        exp_tr = '{8'h80, 8'hC0, 8'hA0, 8'h90, 8'h98, 8'h9C, 8'h9A, 8'h9B};
        srstz = 1'b0; run = 1'b0; sar_model = 1'b0; comp_lvl = 1'b0; sar_target = 8'h9A;
        v_upd = '0; v_wdat = '0; ofs_upd = '0; ofs_wdat = '0;
        en_wr = 1'b0; sar_wr = 1'b0; en_wdat = '0; sta_clr = '0;

        // reset state
        #3;
        chk("rst_busy", busy, 1'b0);
        chk("rst_ptr", cs_ptr, 5'd0);
        chk("rst_code", dac_code, 8'h00);
        chk("rst_regs", {r_dac_en, r_sar_en, r_comp, r_sta, o_intr, cycle_done}, 74'd0);
        tick();
        srstz = 1'b1;

        // en_wr and sar_wr together both load en_wdat
        wr_en(1'b1, 1'b1, 18'h00003);
        chk("dual_dacen", r_dac_en, 18'h00003);
        chk("dual_saren", r_sar_en, 18'h00003);

        // asynchronous reset in the middle of a SAR conversion
        do_reset();
        wr_en(1'b0, 1'b1, 18'h00008);
        sar_model = 1'b1;
        run = 1'b1;
        for (int c = 1; c <= 10; c++) tick();
        chk("midsar_busy", busy, 1'b1);
        chk("midsar_ptr", cs_ptr, 5'd3);
        #2 srstz = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_ptr", cs_ptr, 5'd0);
        chk("arst_code", dac_code, 8'h00);
        chk("arst_saren", r_sar_en, 18'h0);
        chk("arst_sarv", r_sarv, 144'd0);
        run = 1'b0;
        tick();
        srstz = 1'b1;

        // offset saturation on channel 0, writes made during the compare
        do_reset();
        wr_vo(18'h1, 18'h1, 8'hF0, 8'h20);
        wr_en(1'b1, 1'b0, 18'h00001);
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("sat_seek_ptr", cs_ptr, 5'd0);
        tick();
        chk("sat_hi", dac_code, 8'hFF);
        wr_vo(18'h1, 18'h1, 8'h10, 8'hE0);
        chk("sat_lo", dac_code, 8'h00);
        wr_vo(18'h1, 18'h1, 8'h80, 8'hFF);
        chk("sat_mid", dac_code, 8'h7F);
        chk("sat_regs", {r_dacvs[7:0], r_ofs[7:0]}, 16'h80FF);
        tick();
        chk("sat_c4_busy", busy, 1'b1);
        tick();
        chk("sat_idle_busy", busy, 1'b0);
        chk("sat_idle_code", dac_code, 8'h00);
        chk("sat_comp", {r_comp, r_sta}, 36'd0);

        // compare scan of channels 0 and 2 with comparator high
        do_reset();
        wr_en(1'b1, 1'b0, 18'h00005);
        comp_lvl = 1'b1;
        run = 1'b1;
        tick();
        chk("scan_c0_busy", busy, 1'b1);
        for (int c = 1; c <= 27; c++) begin
            tick();
            if (c == 4)  chk("scan_c4_comp", r_comp, 18'h0);
            if (c == 5)  chk("scan_c5_comp", r_comp, 18'h1);
            if (c == 10) chk("scan_c10_ptr", cs_ptr, 5'd2);
            if (c == 10) chk("scan_c10_comp", r_comp, 18'h1);
            if (c == 11) chk("scan_c11_comp", r_comp, 18'h5);
            if (c == 25) chk("scan_c25_done", {cs_ptr, cycle_done}, {5'd17, 1'b0});
            if (c == 26) chk("scan_c26_done", {cs_ptr, cycle_done}, {5'd17, 1'b1});
            if (c == 27) chk("scan_c27_idle", {busy, cycle_done, cs_ptr}, 7'd0);
            if (c == 25) run = 1'b0;
        end
        chk("scan_sta", r_sta, 18'h5);
        chk("scan_intr", o_intr, 1'b1);

        // SAR conversion on channel 3, run dropped mid-conversion
        do_reset();
        wr_en(1'b0, 1'b1, 18'h00008);
        sar_model = 1'b1;
        run = 1'b1;
        tick();
        for (int c = 1; c <= 36; c++) begin
            tick();
            if (c == 5) run = 1'b0;
            if (c == 4) chk("sar_ptr", cs_ptr, 5'd3);
            if (c >= 4 && c < 36 && ((c - 4) % 4) == 0)
                chk($sformatf("sar_trial%0d", (c - 4) / 4), dac_code, exp_tr[(c - 4) / 4]);
            if (c == 35) chk("sarv_pre", r_sarv[31:24], 8'h00);
            if (c == 36) chk("sarv_post", r_sarv[31:24], 8'h9A);
            if (c == 36) chk("sar_idle", {busy, cs_ptr, r_comp, r_sta}, 42'd0);
        end

        // status set colliding with status clear
        do_reset();
        wr_en(1'b1, 1'b0, 18'h00001);
        comp_lvl = 1'b1;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int c = 1; c <= 4; c++) tick();
        chk("coll_pre_sta", r_sta, 18'h0);
        sta_clr = 18'h1;
        tick();
        sta_clr = 18'h0;
        chk("coll_sta", r_sta, 18'h1);
        chk("coll_comp", r_comp, 18'h1);
        chk("coll_intr", o_intr, 1'b1);
        sta_clr = 18'h1;
        tick();
        sta_clr = 18'h0;
        chk("clr_sta", r_sta, 18'h0);
        chk("clr_intr", o_intr, 1'b0);

        // run dropped during channel 2 compare
        do_reset();
        wr_en(1'b1, 1'b0, 18'h00007);
        comp_lvl = 1'b1;
        run = 1'b1;
        seen_done = 1'b0;
        tick();
        for (int c = 1; c <= 15; c++) begin
            tick();
            seen_done = seen_done | cycle_done;
            if (c == 12) chk("drop_c12_ptr", cs_ptr, 5'd2);
            if (c == 12) run = 1'b0;
            if (c == 14) chk("drop_c14_comp", r_comp, 18'h3);
            if (c == 15) chk("drop_c15_comp", r_comp, 18'h7);
            if (c == 15) chk("drop_c15_idle", {busy, cs_ptr}, 6'd0);
        end
        chk("drop_no_done", seen_done, 1'b0);
        chk("drop_sta", r_sta, 18'h7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
